// File: rtl/prev_knn_history_cache_if.sv
// Bundles the write, parallel-read and streaming-read signals of the
// previous-KNN history cache. The master side is the surrounding
// datapath (top-K sorter, distance-compare stage, control); the slave
// side is the cache itself.
interface prev_knn_history_cache_if #(
  parameter int K       = 8,
  parameter int ENTRY_W = 48,
  parameter int N_SLOTS = 4
);
  localparam int LB_W  = $clog2(N_SLOTS);
  localparam int IDX_W = $clog2(K) + 1;
  localparam int SET_W = K * ENTRY_W;

  // Write side (top-K sorter)
  logic               wr_valid;
  logic [SET_W-1:0]   wr_data;
  logic               flush;

  // Parallel read port
  logic [LB_W-1:0]    par_lookback;
  logic [SET_W-1:0]   par_data;
  logic               par_valid;

  // Streaming read port
  logic               strm_start;
  logic [LB_W-1:0]    strm_lookback;
  logic               strm_valid;
  logic               strm_ready;
  logic [ENTRY_W-1:0] strm_data;
  logic [IDX_W-1:0]   strm_idx;
  logic               strm_last;
  logic               strm_busy;
  logic               strm_miss;

  modport master (
    output wr_valid, wr_data, flush,
    output par_lookback,
    input  par_data, par_valid,
    output strm_start, strm_lookback, strm_ready,
    input  strm_valid, strm_data, strm_idx, strm_last, strm_busy, strm_miss
  );

  modport slave (
    input  wr_valid, wr_data, flush,
    input  par_lookback,
    output par_data, par_valid,
    input  strm_start, strm_lookback, strm_ready,
    output strm_valid, strm_data, strm_idx, strm_last, strm_busy, strm_miss
  );
endinterface

// File: rtl/prev_knn_history_cache.sv
// Ring of N_SLOTS top-K result sets from the most recent queries.
// A parallel port exposes one whole set combinationally; a streaming
// port replays one set entry-by-entry from a private snapshot so that
// later writes or flushes cannot disturb a replay in flight.
module prev_knn_history_cache #(
  parameter int K       = 8,
  parameter int ENTRY_W = 48,
  parameter int N_SLOTS = 4
) (
  input logic                      clk,
  input logic                      rst_n,
  prev_knn_history_cache_if.slave  bus
);

  localparam int PTR_W = $clog2(N_SLOTS);
  localparam int CNT_W = PTR_W + 1;
  localparam int KI_W  = $clog2(K);
  localparam int SET_W = K * ENTRY_W;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  // Ring storage and bookkeeping
  logic [SET_W-1:0]   slot_q [N_SLOTS];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [CNT_W-1:0]   count_q;

  // Replay state
  state_t             state_q;
  state_t             state_d;
  logic [ENTRY_W-1:0] snap_q [K];
  logic [KI_W-1:0]    idx_q;
  logic               miss_q;

  // Derived selects and handshake terms
  logic [PTR_W-1:0]   par_sel;
  logic [PTR_W-1:0]   strm_sel;
  logic [SET_W-1:0]   strm_src;
  logic               strm_hit;
  logic               start_ok;
  logic               start_miss;
  logic               streaming;
  logic               at_last;
  logic               xfer;

  // Lookback 0 is the slot just behind the write pointer; the modular
  // subtraction relies on N_SLOTS being a power of two.
  assign par_sel  = wr_ptr_q - PTR_W'(1) - bus.par_lookback;
  assign strm_sel = wr_ptr_q - PTR_W'(1) - bus.strm_lookback;
  assign strm_src = slot_q[strm_sel];

  // A lookback is reachable only if that many sets were written since
  // the last flush (count saturates at N_SLOTS).
  assign strm_hit   = {1'b0, bus.strm_lookback} < count_q;
  assign streaming  = (state_q == STREAM);
  assign start_ok   = (state_q == IDLE) && bus.strm_start && strm_hit;
  assign start_miss = (state_q == IDLE) && bus.strm_start && !strm_hit;
  assign at_last    = (idx_q == KI_W'(K - 1));
  assign xfer       = streaming && bus.strm_ready;

  // Ring write, pointer advance and saturating occupancy count.
  // Flush only clears the count; a simultaneous write lands on top of
  // the flush, so the new set becomes the sole reachable entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the slot array is reset on purpose so that the parallel
      // port never exposes X data, even though par_valid gates it.
      for (int s = 0; s < N_SLOTS; s++) begin
        slot_q[s] <= '0;
      end
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: all state updates use non-blocking assignments so every
      // register samples pre-edge values, which is what makes the
      // same-cycle start/write case read the previous set.
      if (bus.wr_valid) begin
        slot_q[wr_ptr_q] <= bus.wr_data;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (bus.flush) begin
        count_q <= bus.wr_valid ? CNT_W'(1) : '0;
      end else if (bus.wr_valid && (count_q != CNT_W'(N_SLOTS))) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  // Parallel port: pure function of registered state, zero latency.
  assign bus.par_data  = slot_q[par_sel];
  assign bus.par_valid = {1'b0, bus.par_lookback} < count_q;

  // Replay FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Replay FSM next state: a hit launches a replay, the final accepted
  // entry ends it; starts during a replay are ignored.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch
    // is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok)        state_d = STREAM;
      STREAM:  if (xfer && at_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Snapshot capture, entry index advance and registered miss pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < K; e++) begin
        snap_q[e] <= '0;
      end
      idx_q  <= '0;
      miss_q <= 1'b0;
    end else begin
      miss_q <= start_miss;
      if (start_ok) begin
        for (int e = 0; e < K; e++) begin
          snap_q[e] <= strm_src[e*ENTRY_W +: ENTRY_W];
        end
        idx_q <= '0;
      end else if (xfer && !at_last) begin
        idx_q <= idx_q + KI_W'(1);
      end
    end
  end

  // Streaming outputs; everything is held while strm_ready is low
  // because idx_q and the snapshot only move on a transfer or a start.
  assign bus.strm_valid = streaming;
  assign bus.strm_busy  = streaming;
  assign bus.strm_data  = snap_q[idx_q];
  assign bus.strm_idx   = {1'b0, idx_q};
  assign bus.strm_last  = streaming && at_last;
  assign bus.strm_miss  = miss_q;

endmodule

// File: tb/tb_prev_knn_history_cache.sv
// Directed bench for prev_knn_history_cache: a table of parallel-port
// lookups plus hand-written replay sequences for stalls, overwrite
// during replay, misses, flush+write and mid-replay reset.
module tb_prev_knn_history_cache;

  localparam int K       = 8;
  localparam int ENTRY_W = 48;
  localparam int N_SLOTS = 4;
  localparam int SET_W   = K * ENTRY_W;

  typedef struct {
    logic [1:0] lb;
    logic       exp_valid;
    logic [7:0] exp_tag;
  } par_vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  par_vec_t vecs [8];

  prev_knn_history_cache_if #(.K(K), .ENTRY_W(ENTRY_W), .N_SLOTS(N_SLOTS)) bus ();

  prev_knn_history_cache #(.K(K), .ENTRY_W(ENTRY_W), .N_SLOTS(N_SLOTS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [ENTRY_W-1:0] entry_of(input logic [7:0] tag, input int i);
    logic [15:0] e;
    e = {tag, 8'(i)};
    return ENTRY_W'(e);
  endfunction

  function automatic logic [SET_W-1:0] make_set(input logic [7:0] tag);
    logic [SET_W-1:0] s;
    for (int i = 0; i < K; i++) s[i*ENTRY_W +: ENTRY_W] = entry_of(tag, i);
    return s;
  endfunction

  task automatic check(input string name, input logic [SET_W-1:0] act, input logic [SET_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n             = 1'b0;
    bus.wr_valid      = 1'b0;
    bus.wr_data       = '0;
    bus.flush         = 1'b0;
    bus.par_lookback  = '0;
    bus.strm_start    = 1'b0;
    bus.strm_lookback = '0;
    bus.strm_ready    = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic write_set(input logic [7:0] tag);
    bus.wr_valid = 1'b1;
    bus.wr_data  = make_set(tag);
    step();
    bus.wr_valid = 1'b0;
  endtask

  task automatic apply_vec(input par_vec_t v);
    bus.par_lookback = v.lb;
    #1;
    check($sformatf("par_valid lb%0d", v.lb), SET_W'(bus.par_valid), SET_W'(v.exp_valid));
    if (v.exp_valid) check($sformatf("par_data lb%0d", v.lb), bus.par_data, make_set(v.exp_tag));
  endtask

  // Starts a replay (start already applied by caller's step) and drains
  // it with strm_ready held high, checking every entry.
  task automatic drain_replay(input logic [7:0] tag);
    bus.strm_ready = 1'b1;
    for (int i = 0; i < K; i++) begin
      check($sformatf("drain valid %0d", i), SET_W'(bus.strm_valid), SET_W'(1));
      check($sformatf("drain idx %0d", i), SET_W'(bus.strm_idx), SET_W'(i));
      check($sformatf("drain data %0d", i), SET_W'(bus.strm_data), SET_W'(entry_of(tag, i)));
      check($sformatf("drain last %0d", i), SET_W'(bus.strm_last), SET_W'(i == K - 1));
      step();
    end
    check("drain valid after", SET_W'(bus.strm_valid), SET_W'(0));
    check("drain busy after", SET_W'(bus.strm_busy), SET_W'(0));
  endtask

  // Watchdog: the directed sequence is far shorter than this.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  exp_idx;
    int  cyc;
    bit  done;

    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{2'd0, 1'b1, 8'h0C};
    vecs[1] = '{2'd1, 1'b1, 8'h0B};
    vecs[2] = '{2'd2, 1'b1, 8'h0A};
    vecs[3] = '{2'd3, 1'b0, 8'h00};
    vecs[4] = '{2'd0, 1'b1, 8'h0E};
    vecs[5] = '{2'd1, 1'b1, 8'h0D};
    vecs[6] = '{2'd2, 1'b1, 8'h0C};
    vecs[7] = '{2'd3, 1'b1, 8'h0B};

    // Reset state
    do_reset();
    check("rst par_valid", SET_W'(bus.par_valid), SET_W'(0));
    check("rst strm_valid", SET_W'(bus.strm_valid), SET_W'(0));
    check("rst strm_busy", SET_W'(bus.strm_busy), SET_W'(0));
    check("rst strm_miss", SET_W'(bus.strm_miss), SET_W'(0));
    check("rst strm_last", SET_W'(bus.strm_last), SET_W'(0));
    check("rst strm_idx", SET_W'(bus.strm_idx), SET_W'(0));
    check("rst strm_data", SET_W'(bus.strm_data), SET_W'(0));

    // A, B, C then lookups; then D, E wrap the ring
    write_set(8'h0A);
    write_set(8'h0B);
    write_set(8'h0C);
    for (int v = 0; v < 4; v++) apply_vec(vecs[v]);
    write_set(8'h0D);
    write_set(8'h0E);
    for (int v = 4; v < 8; v++) apply_vec(vecs[v]);

    // Straight replay of A with ready held high
    do_reset();
    write_set(8'h0A);
    bus.strm_ready    = 1'b1;
    bus.strm_lookback = 2'd0;
    bus.strm_start    = 1'b1;
    check("pre-start valid", SET_W'(bus.strm_valid), SET_W'(0));
    step();
    bus.strm_start = 1'b0;
    drain_replay(8'h0A);

    // Stalled replay of A while A's slot is overwritten, with a second
    // start issued mid-stream
    do_reset();
    write_set(8'h0A);
    bus.strm_lookback = 2'd0;
    bus.strm_start    = 1'b1;
    step();
    bus.strm_start = 1'b0;
    exp_idx = 0;
    cyc     = 0;
    done    = 1'b0;
    while (!done && cyc < 64) begin
      check($sformatf("stall valid c%0d", cyc), SET_W'(bus.strm_valid), SET_W'(1));
      check($sformatf("stall idx c%0d", cyc), SET_W'(bus.strm_idx), SET_W'(exp_idx));
      check($sformatf("stall data c%0d", cyc), SET_W'(bus.strm_data), SET_W'(entry_of(8'h0A, exp_idx)));
      check($sformatf("stall last c%0d", cyc), SET_W'(bus.strm_last), SET_W'(exp_idx == K - 1));
      check($sformatf("stall miss c%0d", cyc), SET_W'(bus.strm_miss), SET_W'(0));
      bus.strm_ready = (cyc % 3 == 0);
      bus.wr_valid   = (cyc < 4);
      bus.wr_data    = make_set(8'(8'h10 + cyc));
      bus.strm_start = (cyc == 2);
      step();
      bus.wr_valid   = 1'b0;
      bus.strm_start = 1'b0;
      if (bus.strm_ready) begin
        if (exp_idx == K - 1) done = 1'b1;
        else exp_idx++;
      end
      cyc++;
    end
    check("stall replay completed in budget", SET_W'(done), SET_W'(1));
    bus.strm_ready = 1'b0;
    check("stall valid after", SET_W'(bus.strm_valid), SET_W'(0));
    apply_vec('{2'd0, 1'b1, 8'h13});
    apply_vec('{2'd3, 1'b1, 8'h10});

    // Start and write in the same cycle: lookback 0 replays the older set
    do_reset();
    write_set(8'h0A);
    bus.wr_valid      = 1'b1;
    bus.wr_data       = make_set(8'h0B);
    bus.strm_lookback = 2'd0;
    bus.strm_start    = 1'b1;
    step();
    bus.wr_valid   = 1'b0;
    bus.strm_start = 1'b0;
    drain_replay(8'h0A);
    apply_vec('{2'd0, 1'b1, 8'h0B});

    // Miss on empty cache, then flush and flush+write
    do_reset();
    bus.strm_lookback = 2'd0;
    bus.strm_start    = 1'b1;
    step();
    bus.strm_start = 1'b0;
    check("miss pulse", SET_W'(bus.strm_miss), SET_W'(1));
    check("miss valid", SET_W'(bus.strm_valid), SET_W'(0));
    step();
    check("miss cleared", SET_W'(bus.strm_miss), SET_W'(0));
    check("miss valid later", SET_W'(bus.strm_valid), SET_W'(0));
    write_set(8'h0A);
    write_set(8'h0B);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    apply_vec('{2'd0, 1'b0, 8'h00});
    bus.flush    = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_data  = make_set(8'h0F);
    step();
    bus.flush    = 1'b0;
    bus.wr_valid = 1'b0;
    apply_vec('{2'd0, 1'b1, 8'h0F});
    apply_vec('{2'd1, 1'b0, 8'h00});

    // Asynchronous reset in the middle of a replay
    do_reset();
    write_set(8'h0A);
    bus.strm_ready    = 1'b1;
    bus.strm_lookback = 2'd0;
    bus.strm_start    = 1'b1;
    step();
    bus.strm_start   = 1'b0;
    bus.par_lookback = 2'd0;
    step();
    step();
    step();
    check("pre-abort idx", SET_W'(bus.strm_idx), SET_W'(3));
    rst_n = 1'b0;
    #1;
    check("abort strm_valid", SET_W'(bus.strm_valid), SET_W'(0));
    check("abort strm_busy", SET_W'(bus.strm_busy), SET_W'(0));
    check("abort par_valid", SET_W'(bus.par_valid), SET_W'(0));
    check("abort strm_idx", SET_W'(bus.strm_idx), SET_W'(0));
    @(negedge clk);
    rst_n          = 1'b1;
    bus.strm_ready = 1'b0;
    step();
    bus.strm_start = 1'b1;
    step();
    bus.strm_start = 1'b0;
    check("post-abort miss", SET_W'(bus.strm_miss), SET_W'(1));
    check("post-abort valid", SET_W'(bus.strm_valid), SET_W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
